// File: rtl/mips_mc_control_fsm.sv
// Moore control unit for the multi-cycle MIPS datapath: one state per clock,
// every datapath strobe decoded from the state register.
module mips_mc_control_fsm #(
    parameter logic [3:0] ALU_AND = 4'h0,
    parameter logic [3:0] ALU_OR  = 4'h1,
    parameter logic [3:0] ALU_ADD = 4'h2,
    parameter logic [3:0] ALU_SUB = 4'h6,
    parameter logic [3:0] ALU_SLT = 4'h7,
    parameter logic [3:0] ALU_NOR = 4'hC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       BranchEq,
    output logic       BranchNeq,
    output logic       PCSrc,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [3:0] state_o,
    output logic       illegal_o
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REX    = 4'd6,
        RWB    = 4'd7,
        BR     = 4'd8,
        IEX    = 4'd9,
        IWB    = 4'd10
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    state_t state, state_next;

    // State register; reset always lands in FETCH so release starts a fetch.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Next-state and Moore output decode; reset masks every write strobe.
    always_comb begin
        state_next = FETCH;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        BranchEq   = 1'b0;
        BranchNeq  = 1'b0;
        PCSrc      = 1'b0;
        ALUSrcA    = 1'b0;
        RegWrite   = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        illegal_o  = 1'b0;
        case (state)
            FETCH: begin
                IRWrite    = 1'b1;
                ALUSrcB    = 2'b01;
                PCWrite    = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW:                       state_next = MEMADR;
                    OP_BEQ, OP_BNE:                     state_next = BR;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_next = IEX;
                    OP_R: begin
                        case (Funct)
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT:
                                state_next = REX;
                            default: begin
                                illegal_o  = 1'b1;
                                state_next = FETCH;
                            end
                        endcase
                    end
                    default: begin
                        illegal_o  = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = (Op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                IorD       = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                state_next = FETCH;
            end
            REX: begin
                ALUSrcA = 1'b1;
                case (Funct)
                    FN_SUB:  ALUControl = ALU_SUB;
                    FN_AND:  ALUControl = ALU_AND;
                    FN_OR:   ALUControl = ALU_OR;
                    FN_NOR:  ALUControl = ALU_NOR;
                    FN_SLT:  ALUControl = ALU_SLT;
                    default: ALUControl = ALU_ADD;
                endcase
                state_next = RWB;
            end
            RWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            BR: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 1'b1;
                BranchEq   = (Op == OP_BEQ);
                BranchNeq  = (Op == OP_BNE);
                state_next = FETCH;
            end
            IEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (Op)
                    OP_ANDI: ALUControl = ALU_AND;
                    OP_ORI:  ALUControl = ALU_OR;
                    OP_SLTI: ALUControl = ALU_SLT;
                    default: ALUControl = ALU_ADD;
                endcase
                state_next = IWB;
            end
            IWB: begin
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            default: begin
                // Unreachable codes: everything quiet, recover to FETCH.
                ALUControl = 4'h0;
                state_next = FETCH;
            end
        endcase
        if (reset) begin
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            BranchEq  = 1'b0;
            BranchNeq = 1'b0;
            illegal_o = 1'b0;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_mips_mc_control_fsm.sv
// Directed bench for the multi-cycle MIPS control FSM.
module tb_mips_mc_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       IorD, MemWrite, IRWrite, PCWrite, BranchEq, BranchNeq;
    logic       PCSrc, ALUSrcA, RegWrite, MemtoReg, RegDst;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUControl;
    logic [3:0] state_o;
    logic       illegal_o;

    int checks = 0;
    int failures = 0;

    mips_mc_control_fsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .BranchEq(BranchEq), .BranchNeq(BranchNeq), .PCSrc(PCSrc),
        .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .state_o(state_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        Op    = 6'd0;
        Funct = 6'd0;
        step(); step(); step();
        check("rst_state", 8'(state_o), 8'd0);
        check("rst_pcwrite", 8'(PCWrite), 8'd0);
        check("rst_irwrite", 8'(IRWrite), 8'd0);
        check("rst_memwrite", 8'(MemWrite), 8'd0);
        check("rst_regwrite", 8'(RegWrite), 8'd0);
        check("rst_br", 8'({BranchEq, BranchNeq, illegal_o}), 8'd0);

        reset = 1'b0;
        #1;
        check("fetch_pcwrite", 8'(PCWrite), 8'd1);
        check("fetch_irwrite", 8'(IRWrite), 8'd1);
        check("fetch_srcb", 8'(ALUSrcB), 8'd1);

        // lw: 0,1,2,3,4
        Op = 6'b100011;
        step();
        check("lw_s1", 8'(state_o), 8'd1);
        check("lw_s1_srcb", 8'(ALUSrcB), 8'd3);
        step();
        check("lw_s2", 8'(state_o), 8'd2);
        check("lw_s2_src", 8'({ALUSrcA, ALUSrcB}), 8'b110);
        step();
        check("lw_s3", 8'(state_o), 8'd3);
        check("lw_s3_iord", 8'(IorD), 8'd1);
        step();
        check("lw_s4", 8'(state_o), 8'd4);
        check("lw_s4_wb", 8'({RegWrite, MemtoReg, RegDst}), 8'b110);
        step();
        check("lw_end", 8'(state_o), 8'd0);

        // sw: 0,1,2,5
        Op = 6'b101011;
        step();
        check("sw_s1", 8'(state_o), 8'd1);
        step();
        check("sw_s2_regwrite", 8'(RegWrite), 8'd0);
        step();
        check("sw_s5", 8'(state_o), 8'd5);
        check("sw_s5_mem", 8'({MemWrite, IorD, RegWrite}), 8'b110);
        step();
        check("sw_end", 8'(state_o), 8'd0);

        // R-type sub
        Op = 6'b000000; Funct = 6'b100010;
        step();
        step();
        check("sub_s6", 8'(state_o), 8'd6);
        check("sub_alu", 8'(ALUControl), 8'h6);
        check("sub_src", 8'({ALUSrcA, ALUSrcB}), 8'b100);
        step();
        check("sub_s7", 8'(state_o), 8'd7);
        check("sub_wb", 8'({RegDst, RegWrite, MemtoReg}), 8'b110);
        step();
        check("sub_end", 8'(state_o), 8'd0);

        // R-type nor
        Funct = 6'b100111;
        step(); step();
        check("nor_alu", 8'(ALUControl), 8'hC);
        step(); step();
        check("nor_end", 8'(state_o), 8'd0);

        // bne: 3 cycles
        Op = 6'b000101;
        step(); step();
        check("bne_s8", 8'(state_o), 8'd8);
        check("bne_strobes", 8'({BranchNeq, BranchEq, PCSrc}), 8'b101);
        check("bne_alu", 8'(ALUControl), 8'h6);
        step();
        check("bne_end", 8'(state_o), 8'd0);

        // beq
        Op = 6'b000100;
        step(); step();
        check("beq_strobes", 8'({BranchNeq, BranchEq, PCSrc}), 8'b011);
        step();
        check("beq_end", 8'(state_o), 8'd0);

        // ori then slti
        Op = 6'b001101;
        step(); step();
        check("ori_s9", 8'(state_o), 8'd9);
        check("ori_alu", 8'(ALUControl), 8'h1);
        check("ori_src", 8'({ALUSrcA, ALUSrcB}), 8'b110);
        step();
        check("ori_s10", 8'(state_o), 8'd10);
        check("ori_wb", 8'({RegWrite, RegDst, MemtoReg}), 8'b100);
        step();
        Op = 6'b001010;
        step(); step();
        check("slti_alu", 8'(ALUControl), 8'h7);
        step(); step();
        check("slti_end", 8'(state_o), 8'd0);

        // illegal opcode
        Op = 6'b111111;
        step();
        check("ill_op_pulse", 8'(illegal_o), 8'd1);
        check("ill_op_s1", 8'(state_o), 8'd1);
        step();
        check("ill_op_end", 8'({state_o, illegal_o}), 8'd0);

        // illegal funct under R-type
        Op = 6'b000000; Funct = 6'b000000;
        step();
        check("ill_fn_pulse", 8'(illegal_o), 8'd1);
        step();
        check("ill_fn_end", 8'(state_o), 8'd0);
        check("ill_fn_noreg", 8'(RegWrite), 8'd0);

        // reset mid-lw in MEMRD
        Op = 6'b100011;
        step(); step(); step();
        check("abort_s3", 8'(state_o), 8'd3);
        reset = 1'b1;
        #1;
        check("abort_regwrite", 8'(RegWrite), 8'd0);
        step();
        check("abort_state", 8'(state_o), 8'd0);
        check("abort_regwrite2", 8'(RegWrite), 8'd0);
        reset = 1'b0;
        #1;
        check("abort_refetch", 8'({PCWrite, IRWrite}), 8'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
